traffic_lights_cmd_gen: RTL and testbench

//  Command initiator for the traffic-light controller's cmd_type/cmd_valid/cmd_data bus.

---
 rtl/traffic_lights_cmd_gen.sv | 167 ++++++++++++++++
 tb/tb_traffic_lights_cmd_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : traffic_lights_cmd_gen
// Brief    : Expands one high-level request into the controller command sequence.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_lights_cmd_gen #(
  parameter int GAP_CYCLES = 2,
  parameter int DATA_W     = 16,
  parameter int CMD_W      = 3
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_green_i,
  input  logic [DATA_W-1:0] req_red_i,
  input  logic [DATA_W-1:0] req_yellow_i,
  output logic [CMD_W-1:0]  cmd_type_o,
  output logic              cmd_valid_o,
  output logic [DATA_W-1:0] cmd_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_send = 2'd1;
  localparam logic [1:0] c_gap  = 2'd2;

  localparam logic [1:0] c_op_reconfig = 2'd0;
  localparam logic [1:0] c_op_off      = 2'd1;
  localparam logic [1:0] c_op_on       = 2'd2;

  localparam int c_cnt_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_green;
  logic [DATA_W-1:0] r_red;
  logic [DATA_W-1:0] r_yellow;
  logic [2:0]        r_step;
  logic [c_cnt_w-1:0] r_gap_cnt;
  logic              r_done;
  logic              w_accept;
  logic              w_gap_last;
  logic              w_next_found;
  logic [2:0]        w_next_step;

  function automatic logic step_exists(input logic [1:0] op, input logic [2:0] idx);
    case (op)
      c_op_reconfig: step_exists = (idx < 3'd6);
      c_op_off,
      c_op_on:       step_exists = (idx == 3'd0);
      default:       step_exists = (idx < 3'd2);
    endcase
  endfunction

  // Only the three period writes of RECONFIG can be skipped.
  function automatic logic step_skipped(input logic [1:0] op, input logic [2:0] idx,
                                        input logic g_zero, input logic r_zero,
                                        input logic y_zero);
    step_skipped = (op == c_op_reconfig) &&
                   (((idx == 3'd2) && g_zero) || ((idx == 3'd3) && r_zero) ||
                    ((idx == 3'd4) && y_zero));
  endfunction

  function automatic logic [CMD_W-1:0] step_type(input logic [1:0] op, input logic [2:0] idx);
    case (op)
      c_op_reconfig: begin
        case (idx)
          3'd1:    step_type = CMD_W'(2);
          3'd2:    step_type = CMD_W'(3);
          3'd3:    step_type = CMD_W'(4);
          3'd4:    step_type = CMD_W'(5);
          default: step_type = CMD_W'(0);
        endcase
      end
      c_op_off: step_type = CMD_W'(1);
      c_op_on:  step_type = CMD_W'(0);
      default:  step_type = (idx == 3'd1) ? CMD_W'(2) : CMD_W'(0);
    endcase
  endfunction

  assign w_accept   = (r_state == c_idle) && req_valid_i;
  assign w_gap_last = (r_state == c_gap) && (r_gap_cnt == '0);

  // Lowest-indexed remaining step wins, hence the descending scan.
  always_comb begin
    w_next_found = 1'b0;
    w_next_step  = r_step;
    for (int i = 7; i >= 0; i--) begin
      if ((3'(i) > r_step) && step_exists(r_op, 3'(i)) &&
          !step_skipped(r_op, 3'(i), (r_green == '0), (r_red == '0), (r_yellow == '0))) begin
        w_next_found = 1'b1;
        w_next_step  = 3'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_nxt = c_send;
      c_send:  w_state_nxt = c_gap;
      c_gap:   if (w_gap_last) w_state_nxt = w_next_found ? c_send : c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_op      <= '0;
      r_green   <= '0;
      r_red     <= '0;
      r_yellow  <= '0;
      r_step    <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_gap_last && !w_next_found;
      if (w_accept) begin
        r_op     <= req_op_i;
        r_green  <= req_green_i;
        r_red    <= req_red_i;
        r_yellow <= req_yellow_i;
        r_step   <= '0;
      end else if (w_gap_last && w_next_found) begin
        r_step <= w_next_step;
      end
      if (r_state == c_send) begin
        r_gap_cnt <= c_cnt_w'(GAP_CYCLES - 1);
      end else if ((r_state == c_gap) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    cmd_valid_o = (r_state == c_send);
    cmd_type_o  = '0;
    cmd_data_o  = '0;
    if (r_state == c_send) begin
      cmd_type_o = step_type(r_op, r_step);
      case ({(r_op == c_op_reconfig), r_step})
        4'b1_010: cmd_data_o = r_green;
        4'b1_011: cmd_data_o = r_red;
        4'b1_100: cmd_data_o = r_yellow;
        default:  cmd_data_o = '0;
      endcase
    end
    req_ready_o = (r_state == c_idle);
    busy_o      = (r_state != c_idle);
    done_o      = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_traffic_lights_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_lights_cmd_gen
// Brief    : Self-checking bench: vector table, corner sequences, random requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_lights_cmd_gen;

  localparam int G  = 2;
  localparam int DW = 16;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [1:0]    req_op_i = '0;
  logic [DW-1:0] req_green_i = '0;
  logic [DW-1:0] req_red_i = '0;
  logic [DW-1:0] req_yellow_i = '0;
  logic [2:0]    cmd_type_o;
  logic          cmd_valid_o;
  logic [DW-1:0] cmd_data_o;
  logic          busy_o;
  logic          done_o;

  traffic_lights_cmd_gen #(.GAP_CYCLES(G), .DATA_W(DW), .CMD_W(3)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_green_i(req_green_i), .req_red_i(req_red_i), .req_yellow_i(req_yellow_i),
    .cmd_type_o(cmd_type_o), .cmd_valid_o(cmd_valid_o), .cmd_data_o(cmd_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]    t;
    logic [DW-1:0] d;
  } cmd_t;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] g, r, y;
    int            exp_done;
  } vec_t;

  cmd_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference: the command list a request must produce.
  task automatic model(input logic [1:0] op, input logic [DW-1:0] g, r, y);
    exp_q.delete();
    case (op)
      2'd0: begin
        exp_q.push_back('{3'd0, '0});
        exp_q.push_back('{3'd2, '0});
        if (g != 0) exp_q.push_back('{3'd3, g});
        if (r != 0) exp_q.push_back('{3'd4, r});
        if (y != 0) exp_q.push_back('{3'd5, y});
        exp_q.push_back('{3'd0, '0});
      end
      2'd1: exp_q.push_back('{3'd1, '0});
      2'd2: exp_q.push_back('{3'd0, '0});
      default: begin
        exp_q.push_back('{3'd0, '0});
        exp_q.push_back('{3'd2, '0});
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic v, input logic [2:0] t,
                     input logic [DW-1:0] d, input logic dn, input logic rd);
    n_checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o, done_o, req_ready_o, busy_o} !==
        {v, t, d, dn, rd, ~rd}) begin
      n_errors++;
      $display("FAIL %s: got v=%0b t=%0d d=%0d done=%0b rdy=%0b busy=%0b want v=%0b t=%0d d=%0d done=%0b rdy=%0b busy=%0b",
               nm, cmd_valid_o, cmd_type_o, cmd_data_o, done_o, req_ready_o, busy_o,
               v, t, d, dn, rd, ~rd);
    end
  endtask

  // Expected outputs at cycle c after the handshake, from exp_q and timing rules.
  task automatic chk_cycle(input string nm, input int c, input int done_c);
    int  k;
    logic s;
    k = (c - 1) / (G + 1);
    s = (((c - 1) % (G + 1)) == 0) && (k < exp_q.size());
    chk(nm, s, s ? exp_q[k].t : 3'd0, s ? exp_q[k].d : '0, c == done_c, c == done_c);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one request from idle and check every cycle up to and including done.
  task automatic run_req(input string nm, input logic [1:0] op, input logic [DW-1:0] g, r, y,
                         input int done_in, input bit noisy);
    int done_c;
    model(op, g, r, y);
    done_c = (done_in > 0) ? done_in : exp_q.size() * (G + 1) + 1;
    chk({nm, "_pre"}, 1'b0, 3'd0, '0, done_o, 1'b1);
    req_valid_i = 1'b1; req_op_i = op;
    req_green_i = g; req_red_i = r; req_yellow_i = y;
    tick();
    req_valid_i = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
      chk_cycle(nm, c, done_c);
      if (c == done_c) break;
      if (noisy) begin
        req_valid_i  = 1'($urandom_range(0, 1));
        req_op_i     = 2'($urandom_range(0, 3));
        req_green_i  = DW'($urandom);
        req_red_i    = DW'($urandom);
        req_yellow_i = DW'($urandom);
      end
      if (c == done_c - 1) req_valid_i = 1'b0;
      tick();
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{2'd0, 16'd30, 16'd40, 16'd50, 19};
    vecs[1] = '{2'd0, 16'd0,  16'd40, 16'd0,  13};
    vecs[2] = '{2'd1, 16'd0,  16'd0,  16'd0,  4};
    vecs[3] = '{2'd2, 16'd9,  16'd9,  16'd9,  4};
    vecs[4] = '{2'd3, 16'd1,  16'd2,  16'd3,  7};
    vecs[5] = '{2'd0, 16'd0,  16'd0,  16'd0,  10};
    vecs[6] = '{2'd0, 16'd5,  16'd0,  16'd7,  16};

    #1;
    chk("reset_hold", 1'b0, 3'd0, '0, 1'b0, 1'b1);
    tick(); tick();
    arst_ni = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_after_reset", 1'b0, 3'd0, '0, 1'b0, 1'b1);
    end

    foreach (vecs[i]) begin
      run_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].g, vecs[i].r, vecs[i].y,
              vecs[i].exp_done, 1'b0);
      tick();
      chk($sformatf("vec%0d_post", i), 1'b0, 3'd0, '0, 1'b0, 1'b1);
    end

    // OFF then ON with valid held high across both handshakes.
    req_valid_i = 1'b1; req_op_i = 2'd1;
    tick();
    req_op_i = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("b2b_c%0d", c), (c == 1) || (c == 5), (c == 1) ? 3'd1 : 3'd0, '0,
          (c == 4) || (c == 8), (c == 4) || (c == 8));
      if (c == 5) req_valid_i = 1'b0;
      if (c < 8) tick();
    end
    tick();

    // Asynchronous reset in the GAP following the green write.
    model(2'd0, 16'd11, 16'd22, 16'd33);
    req_valid_i = 1'b1; req_op_i = 2'd0;
    req_green_i = 16'd11; req_red_i = 16'd22; req_yellow_i = 16'd33;
    tick();
    req_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk_cycle("rst_pre", c, 19);
      if (c < 8) tick();
    end
    #2 arst_ni = 1'b0;
    #1 chk("rst_async", 1'b0, 3'd0, '0, 1'b0, 1'b1);
    tick();
    arst_ni = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("rst_quiet", 1'b0, 3'd0, '0, 1'b0, 1'b1);
      tick();
    end
    run_req("rst_standby", 2'd3, '0, '0, '0, 7, 1'b0);
    tick();

    // Inputs wiggled while busy must not disturb the sequence.
    run_req("noisy_reconfig", 2'd0, 16'd100, 16'd200, 16'd300, 19, 1'b1);
    tick();

    for (int i = 0; i < 30; i++) begin
      logic [1:0]    op;
      logic [DW-1:0] g, r, y;
      op = 2'($urandom_range(0, 3));
      g  = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom);
      r  = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom);
      y  = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom);
      run_req($sformatf("rand%0d", i), op, g, r, y, 0, (i % 5) == 4);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
